// File: rtl/change_pkg.sv
// Shared definitions for the change dispenser: denominations, their indices and FSM states.
package change_pkg;

    localparam int NDEN   = 4;
    localparam int IDX_1  = 0;
    localparam int IDX_5  = 1;
    localparam int IDX_10 = 2;
    localparam int IDX_50 = 3;

    localparam logic [7:0] DENOM [NDEN] = '{8'd1, 8'd5, 8'd10, 8'd50};

    typedef enum logic [3:0] {
        IDLE,
        PLAN0,
        PLAN1,
        PLAN2,
        PLAN3,
        DISP_HI,
        DISP_LO,
        DONE,
        ERR
    } state_t;

    // Planning runs largest denomination first, so PLAN0 handles the 50s.
    function automatic logic [1:0] plan_index(input state_t s);
        case (s)
            PLAN0:   return 2'(IDX_50);
            PLAN1:   return 2'(IDX_10);
            PLAN2:   return 2'(IDX_5);
            default: return 2'(IDX_1);
        endcase
    endfunction

endpackage

// File: rtl/coin_pulser.sv
// Phase timer for coin pulses: fire loads the high or low phase length, ready flags its last cycle.
module coin_pulser #(
    parameter int PULSE_HI = 1,
    parameter int PULSE_LO = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic fire,
    input  logic hi,
    output logic pulse,
    output logic ready
);

    localparam int MAXP = (PULSE_HI > PULSE_LO) ? PULSE_HI : PULSE_LO;
    localparam int TW   = (MAXP > 1) ? $clog2(MAXP) : 1;

    logic [TW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            pulse <= 1'b0;
        end else if (fire) begin
            cnt   <= hi ? TW'(PULSE_HI - 1) : TW'(PULSE_LO - 1);
            pulse <= hi;
        end else if (cnt != '0) begin
            cnt <= cnt - TW'(1);
        end
    end

    assign ready = (cnt == '0);

endmodule

// File: rtl/change_dispenser.sv
// Greedy change dispenser: plans coins per denomination against stock, then pulses them out.
module change_dispenser
    import change_pkg::*;
#(
    parameter int AMT_W      = 8,
    parameter int STOCK_W    = 6,
    parameter int STOCK_INIT = 10,
    parameter int PULSE_HI   = 1,
    parameter int PULSE_LO   = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [AMT_W-1:0]   amount,
    input  logic               refill,
    input  logic [1:0]         refill_sel,
    input  logic [STOCK_W-1:0] refill_cnt,
    output logic [3:0]         coin_out,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [3:0]         empty
);

    localparam int CW = (AMT_W > STOCK_W) ? AMT_W : STOCK_W;

    state_t             state;
    state_t             next_state;
    logic [AMT_W-1:0]   rem;
    logic [STOCK_W-1:0] stock    [NDEN];
    logic [STOCK_W-1:0] plan     [NDEN];
    logic [STOCK_W-1:0] plan_eff [NDEN];
    logic [1:0]         cur_idx;

    logic [1:0]         plan_idx;
    logic [AMT_W-1:0]   denom;
    logic [AMT_W-1:0]   quot;
    logic [STOCK_W-1:0] n;
    logic [AMT_W-1:0]   rem_next;
    logic [1:0]         sel;
    logic               any_coin;
    logic [STOCK_W:0]   ref_sum;
    logic [STOCK_W-1:0] ref_val;
    logic               fire;
    logic               fire_hi;
    logic               pulse;
    logic               ready;

    coin_pulser #(
        .PULSE_HI(PULSE_HI),
        .PULSE_LO(PULSE_LO)
    ) u_pulser (
        .clk  (clk),
        .rst  (rst),
        .fire (fire),
        .hi   (fire_hi),
        .pulse(pulse),
        .ready(ready)
    );

    // One planning step: as many coins of this denomination as fit, limited by stock.
    always_comb begin
        plan_idx = plan_index(state);
        denom    = AMT_W'(DENOM[plan_idx]);
        quot     = rem / denom;
        if (CW'(quot) < CW'(stock[plan_idx])) begin
            n = STOCK_W'(quot);
        end else begin
            n = stock[plan_idx];
        end
        rem_next = rem - AMT_W'(n) * denom;
    end

    // In PLAN3 the 1-coin count is not registered yet, so splice it in before choosing a coin.
    always_comb begin
        plan_eff = plan;
        if (state == PLAN3) begin
            plan_eff[IDX_1] = n;
        end
        sel      = 2'(IDX_1);
        any_coin = 1'b0;
        for (int i = 0; i < NDEN; i++) begin
            if (plan_eff[i] != '0) begin
                sel      = 2'(i);
                any_coin = 1'b1;
            end
        end
    end

    always_comb begin
        ref_sum = {1'b0, stock[refill_sel]} + {1'b0, refill_cnt};
        ref_val = ref_sum[STOCK_W] ? '1 : ref_sum[STOCK_W-1:0];
    end

    always_comb begin
        next_state = state;
        fire       = 1'b0;
        fire_hi    = 1'b0;
        case (state)
            IDLE:    if (start) next_state = PLAN0;
            PLAN0:   next_state = PLAN1;
            PLAN1:   next_state = PLAN2;
            PLAN2:   next_state = PLAN3;
            PLAN3: begin
                if (rem_next != '0) begin
                    next_state = ERR;
                end else if (any_coin) begin
                    next_state = DISP_HI;
                    fire       = 1'b1;
                    fire_hi    = 1'b1;
                end else begin
                    next_state = DONE;
                end
            end
            DISP_HI: begin
                if (ready) begin
                    next_state = DISP_LO;
                    fire       = 1'b1;
                end
            end
            DISP_LO: begin
                if (ready) begin
                    if (any_coin) begin
                        next_state = DISP_HI;
                        fire       = 1'b1;
                        fire_hi    = 1'b1;
                    end else begin
                        next_state = DONE;
                    end
                end
            end
            DONE:    next_state = IDLE;
            ERR:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Stock and plan are debited together when a coin's high phase is launched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem     <= '0;
            cur_idx <= '0;
            for (int i = 0; i < NDEN; i++) begin
                stock[i] <= STOCK_W'(STOCK_INIT);
                plan[i]  <= '0;
            end
        end else begin
            if (state == IDLE) begin
                if (refill) begin
                    stock[refill_sel] <= ref_val;
                end
                if (start) begin
                    rem <= amount;
                    for (int i = 0; i < NDEN; i++) begin
                        plan[i] <= '0;
                    end
                end
            end
            if (state inside {PLAN0, PLAN1, PLAN2, PLAN3}) begin
                plan[plan_idx] <= n;
                rem            <= rem_next;
            end
            if (fire && fire_hi) begin
                cur_idx    <= sel;
                plan[sel]  <= plan_eff[sel] - STOCK_W'(1);
                stock[sel] <= stock[sel] - STOCK_W'(1);
            end
        end
    end

    always_comb begin
        coin_out = '0;
        if (state == DISP_HI && pulse) begin
            coin_out = 4'b0001 << cur_idx;
        end
        for (int i = 0; i < NDEN; i++) begin
            empty[i] = (stock[i] == '0);
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);
    assign err  = (state == ERR);

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: a greedy model queues expected coin/done/err events, a monitor pops them.
module tb_change_dispenser;

    localparam int AMT_W      = 8;
    localparam int STOCK_W    = 6;
    localparam int STOCK_INIT = 10;
    localparam int P_HI       = 1;
    localparam int P_LO       = 1;
    localparam int STOCK_MAX  = (1 << STOCK_W) - 1;

    typedef struct {
        int kind;
        int idx;
        int cyc;
    } ev_t;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start = 1'b0;
    logic [AMT_W-1:0]   amount = '0;
    logic               refill = 1'b0;
    logic [1:0]         refill_sel = '0;
    logic [STOCK_W-1:0] refill_cnt = '0;
    logic [3:0]         coin_out;
    logic               busy;
    logic               done;
    logic               err;
    logic [3:0]         empty;

    ev_t  exp_q[$];
    int   mstock[4];
    int   denom_m[4] = '{1, 5, 10, 50};
    int   cyc = 0;
    int   t0 = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   done_cnt = 0;
    logic [3:0] prev_coin = '0;
    bit   watch_e3 = 1'b0;

    change_dispenser #(
        .AMT_W(AMT_W),
        .STOCK_W(STOCK_W),
        .STOCK_INIT(STOCK_INIT),
        .PULSE_HI(P_HI),
        .PULSE_LO(P_LO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .amount(amount),
        .refill(refill),
        .refill_sel(refill_sel),
        .refill_cnt(refill_cnt),
        .coin_out(coin_out),
        .busy(busy),
        .done(done),
        .err(err),
        .empty(empty)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string tag, input integer got, input integer exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Pops the next expected event and compares kind, coin index and cycle relative to start.
    task automatic record(input int kind, input int idx);
        ev_t e;
        if (exp_q.size() == 0) begin
            check_output("unexpected_event", kind, -1);
        end else begin
            e = exp_q.pop_front();
            check_output("event_kind", kind, e.kind);
            check_output("event_coin", idx, e.idx);
            check_output("event_cycle", cyc - t0, e.cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check_output("coin_onehot", integer'($onehot0(coin_out)), 1);
            check_output("done_err_excl", integer'(done & err), 0);
            if (watch_e3) check_output("empty50", integer'(empty[3]), 1);
            if (coin_out != 4'b0 && prev_coin == 4'b0) begin
                int b = -1;
                for (int i = 0; i < 4; i++) if (coin_out[i]) b = i;
                record(0, b);
            end
            if (done) begin
                done_cnt++;
                record(1, 0);
            end
            if (err) record(2, 0);
        end
        prev_coin = coin_out;
    end

    function automatic void push_ev(input int kind, input int idx, input int c);
        ev_t e;
        e.kind = kind;
        e.idx  = idx;
        e.cyc  = c;
        exp_q.push_back(e);
    endfunction

    // Greedy reference: largest denomination first, bounded by the model stock.
    function automatic void push_request(input int amt);
        int rem = amt;
        int ns[4];
        int total = 0;
        int k = 0;
        for (int i = 3; i >= 0; i--) begin
            ns[i] = rem / denom_m[i];
            if (ns[i] > mstock[i]) ns[i] = mstock[i];
            rem -= ns[i] * denom_m[i];
            total += ns[i];
        end
        if (rem != 0) begin
            push_ev(2, 0, 5);
        end else begin
            for (int i = 3; i >= 0; i--) begin
                for (int j = 0; j < ns[i]; j++) begin
                    push_ev(0, i, 5 + k * (P_HI + P_LO));
                    k++;
                end
                mstock[i] -= ns[i];
            end
            push_ev(1, 0, 5 + total * (P_HI + P_LO));
        end
    endfunction

    function automatic void model_refill(input int sel, input int cnt);
        mstock[sel] += cnt;
        if (mstock[sel] > STOCK_MAX) mstock[sel] = STOCK_MAX;
    endfunction

    task automatic apply_stimulus(input int amt, input bit do_ref, input int rsel, input int rcnt);
        @(posedge clk);
        #1;
        start      = 1'b1;
        amount     = AMT_W'(amt);
        refill     = do_ref;
        refill_sel = 2'(rsel);
        refill_cnt = STOCK_W'(rcnt);
        t0         = cyc;
        if (do_ref) model_refill(rsel, rcnt);
        push_request(amt);
        @(posedge clk);
        #1;
        start  = 1'b0;
        refill = 1'b0;
    endtask

    task automatic do_refill(input int rsel, input int rcnt);
        @(posedge clk);
        #1;
        refill     = 1'b1;
        refill_sel = 2'(rsel);
        refill_cnt = STOCK_W'(rcnt);
        model_refill(rsel, rcnt);
        @(posedge clk);
        #1;
        refill = 1'b0;
    endtask

    task automatic wait_cycle(input int rel);
        int guard = 0;
        while (cyc < t0 + rel && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0 && !busy) break;
        end
        check_output("pending_events", exp_q.size(), 0);
        check_output("idle_busy", integer'(busy), 0);
    endtask

    task automatic check_stocks();
        for (int i = 0; i < 4; i++) begin
            check_output($sformatf("stock%0d", i), integer'(dut.stock[i]), mstock[i]);
            check_output($sformatf("empty%0d", i), integer'(empty[i]), integer'(mstock[i] == 0));
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 4; i++) mstock[i] = STOCK_INIT;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int d0;
        for (int i = 0; i < 4; i++) mstock[i] = STOCK_INIT;

        // Reset state
        #2 rst = 1'b1;
        #1;
        check_output("rst_coin", coin_out, 0);
        check_output("rst_busy", busy, 0);
        check_output("rst_done", done, 0);
        check_output("rst_err", err, 0);
        check_stocks();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // 87 -> 50, 10x3, 5, 1x2; done at cycle 19
        apply_stimulus(87, 1'b0, 0, 0);
        wait_idle();
        check_stocks();

        // Zero amount completes at cycle 5 with no coins
        apply_stimulus(0, 1'b0, 0, 0);
        wait_idle();

        // Start and refill while busy are ignored
        apply_stimulus(87, 1'b0, 0, 0);
        wait_cycle(6);
        start      = 1'b1;
        amount     = AMT_W'(3);
        refill     = 1'b1;
        refill_sel = 2'd1;
        refill_cnt = STOCK_W'(5);
        @(posedge clk);
        #1;
        start  = 1'b0;
        refill = 1'b0;
        wait_idle();
        check_stocks();

        // Reset during the second pulse aborts the payout
        do_reset();
        apply_stimulus(87, 1'b0, 0, 0);
        wait_cycle(7);
        @(negedge clk);
        #2;
        rst = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 4; i++) mstock[i] = STOCK_INIT;
        #1;
        check_output("abort_coin", coin_out, 0);
        check_output("abort_busy", busy, 0);
        check_output("abort_done", done, 0);
        check_output("abort_err", err, 0);
        check_stocks();
        d0 = done_cnt;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (25) @(negedge clk);
        check_output("abort_no_done", done_cnt, d0);
        check_output("abort_idle", busy, 0);

        // Refill saturates; refill during a payout is dropped
        do_refill(1, 63);
        check_stocks();
        apply_stimulus(5, 1'b0, 0, 0);
        wait_cycle(3);
        refill     = 1'b1;
        refill_sel = 2'd1;
        refill_cnt = STOCK_W'(1);
        @(posedge clk);
        #1 refill = 1'b0;
        wait_idle();
        check_stocks();

        // Drain the 50s, then 60 must come out as six 10s
        apply_stimulus(250, 1'b0, 0, 0);
        wait_idle();
        apply_stimulus(250, 1'b0, 0, 0);
        wait_idle();
        watch_e3 = 1'b1;
        apply_stimulus(60, 1'b0, 0, 0);
        wait_idle();
        watch_e3 = 1'b0;
        check_stocks();

        // Refill in the same cycle as start is visible to planning
        apply_stimulus(50, 1'b1, 3, 1);
        wait_idle();
        check_stocks();

        // Drain 5s and 1s, then exact change is impossible
        do_reset();
        for (int r = 0; r < 10; r++) begin
            apply_stimulus(5, 1'b0, 0, 0);
            wait_idle();
        end
        for (int r = 0; r < 10; r++) begin
            apply_stimulus(1, 1'b0, 0, 0);
            wait_idle();
        end
        check_stocks();
        apply_stimulus(3, 1'b0, 0, 0);
        wait_idle();
        apply_stimulus(15, 1'b0, 0, 0);
        wait_idle();
        check_stocks();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
